// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, status bit positions and serialiser states
package mmio_uart_tx_pkg;
  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;
  localparam int STAT_FULL = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_OVF = 2;
  localparam int STAT_LVL = 8;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_uart_tx_fifo: first-word-fall-through synchronous FIFO with occupancy count
module mmio_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic w_push_ok, w_pop_ok;
  assign o_full = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_dout = r_mem[r_rp];
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
    end else begin
      r_wp <= w_push_ok ? r_wp + AW'(1) : r_wp;
      r_rp <= w_pop_ok ? r_rp + AW'(1) : r_rp;
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and status register
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int CLK_DIV = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int BW = $clog2(CLK_DIV)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ram_rw,
  input  logic [XLEN-1:0] ramAddress,
  inout  wire  [XLEN-1:0] ramData,
  output logic            tx,
  output logic            tx_busy
);
  state_t r_state, w_state_n;
  logic [BW-1:0] r_bcnt, w_bcnt_n;
  logic [2:0] r_bidx, w_bidx_n;
  logic [7:0] r_shift, w_shift_n, w_dout;
  logic r_tx, w_tx_n, r_ovf;
  logic w_sel, w_is_stat, w_push, w_pop, w_clr, w_drop, w_full, w_empty, w_bdone, w_unused;
  logic [LW-1:0] w_level;
  logic [XLEN-1:0] w_status, w_rdata;
  assign w_sel = ramAddress[XLEN-1:3] == BASE_ADDR[XLEN-1:3];
  assign w_is_stat = ramAddress[2] == STATUS_OFF[2];
  assign w_push = ram_rw && w_sel && ramAddress[2] == TXDATA_OFF[2];
  assign w_clr = ram_rw && w_sel && w_is_stat && ramData[STAT_OVF];
  assign w_drop = w_push && w_full && !w_pop;
  assign w_unused = ^{ramAddress[1:0], ramData[XLEN-1:8]};
  always_comb begin
    w_status = '0;
    w_status[STAT_FULL] = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_OVF] = r_ovf;
    w_status[STAT_LVL +: LW] = w_level;
  end
  assign w_rdata = w_is_stat ? w_status : '0;
  assign ramData = (w_sel && !ram_rw) ? w_rdata : 'z;
  mmio_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .i_push(w_push), .i_pop(w_pop), .i_din(ramData[7:0]),
    .o_dout(w_dout), .o_full(w_full), .o_empty(w_empty), .o_level(w_level)
  );
  // a new drop wins over a same-cycle clear so no overflow is ever lost
  always_ff @(posedge clk)
    r_ovf <= reset ? 1'b0 : w_drop ? 1'b1 : w_clr ? 1'b0 : r_ovf;
  assign w_bdone = r_bcnt == '0;
  always_comb begin
    w_state_n = r_state;
    w_bcnt_n = w_bdone ? BW'(CLK_DIV - 1) : r_bcnt - BW'(1);
    w_bidx_n = r_bidx;
    w_shift_n = r_shift;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bcnt_n = r_bcnt;
        if (!w_empty) begin
          w_pop = 1'b1;
          w_shift_n = w_dout;
          w_bcnt_n = BW'(CLK_DIV - 1);
          w_state_n = S_START;
        end
      end
      S_START: if (w_bdone) begin
        w_bidx_n = '0;
        w_state_n = S_DATA;
      end
      S_DATA: if (w_bdone) begin
        w_shift_n = r_shift >> 1;
        w_bidx_n = r_bidx + 3'd1;
        w_state_n = r_bidx == 3'd7 ? S_STOP : S_DATA;
      end
      default: if (w_bdone) w_state_n = S_IDLE;
    endcase
    // line level follows the state being entered so tx comes straight off a flop
    w_tx_n = w_state_n == S_START ? 1'b0 : w_state_n == S_DATA ? w_shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bcnt <= '0;
      r_bidx <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_bcnt <= w_bcnt_n;
      r_bidx <= w_bidx_n;
      r_shift <= w_shift_n;
      r_tx <= w_tx_n;
    end
  end
  assign tx = r_tx;
  assign tx_busy = r_state != S_IDLE || !w_empty;
endmodule
